// File: rtl/matrix_coef_ctrl_pkg.sv
// Shared types and helpers for the colour-matrix coefficient controller:
// coefficient geometry, FSM encoding, bit-slice lookup and identity bank.
package matrix_coef_ctrl_pkg;

    localparam int NUM_COEF  = 9;
    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 10;
    localparam int FCNT_W    = 16;
    localparam int BANK_W    = NUM_COEF * COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_e;

    // Index 0 sits in the MSBs of the packed bank.
    function automatic int coef_lsb(input logic [3:0] idx);
        return COEF_W * (NUM_COEF - 1 - int'(idx));
    endfunction

    function automatic logic [BANK_W-1:0] identity_bank();
        logic [BANK_W-1:0] bank;
        bank = '0;
        for (int k = 0; k < NUM_COEF; k++) begin
            if ((k % 4) == 0) begin
                bank[COEF_W*(NUM_COEF-1-k) +: COEF_W] = COEF_W'(1 << COEF_FRAC);
            end else begin
                bank[COEF_W*(NUM_COEF-1-k) +: COEF_W] = '0;
            end
        end
        return bank;
    endfunction

endpackage

// File: rtl/matrix_coef_ctrl_coef_bank.sv
// Nine-entry coefficient bank with indexed write, bulk load and packed output.
// Used twice by matrix_coef_ctrl: once as shadow bank, once as active bank.
module matrix_coef_ctrl_coef_bank
    import matrix_coef_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_idx_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic              load_en_i,
    input  logic [BANK_W-1:0] load_data_i,
    output logic [BANK_W-1:0] bank_o
);

    logic [BANK_W-1:0] bank_q;
    logic [BANK_W-1:0] bank_d;

    // Bulk load takes priority over an indexed write.
    always_comb begin
        bank_d = bank_q;
        if (load_en_i) begin
            bank_d = load_data_i;
        end else if (wr_en_i && (wr_idx_i <= 4'd8)) begin
            bank_d[coef_lsb(wr_idx_i) +: COEF_W] = wr_data_i;
        end else begin
            bank_d = bank_q;
        end
    end

    // Bank storage, identity after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= identity_bank();
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/matrix_coef_ctrl.sv
// Colour-matrix coefficient controller: shadow/active banks, frame pixel count,
// frame-aligned bank swap. Optional readback port enabled by COEF_READBACK_EN.
module matrix_coef_ctrl
    import matrix_coef_ctrl_pkg::*;
#(
    parameter int FRAME_SIZE = 1920 * 1080
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              cfg_ready_o,
    output logic              cfg_err_o,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic              mult_valid_o,
    output logic [BANK_W-1:0] coef_o,
    output logic              commit_pending_o,
    output logic              frame_done_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic [COEF_W-1:0] cfg_rdata_o
);

    localparam int CNT_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(FRAME_SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              shadow_wr_s, swap_s, pix_ready_s, accept_s;
    logic [BANK_W-1:0] shadow_bank_s, active_bank_s;

    // Sequencing: writes/commits only in IDLE; swap waits for pix_cnt==0.
    always_comb begin
        state_d     = state_q;
        cfg_err_d   = 1'b0;
        shadow_wr_s = 1'b0;
        swap_s      = 1'b0;
        pix_ready_s = 1'b1;
        case (state_q)
            ST_IDLE: begin
                shadow_wr_s = cfg_wr && (cfg_addr <= 4'd8);
                cfg_err_d   = cfg_wr && (cfg_addr > 4'd8);
                if (cfg_commit) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                cfg_err_d = cfg_wr || cfg_commit;
                if (pix_cnt_q == '0) begin
                    pix_ready_s = 1'b0;
                    state_d     = ST_SWAP;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_SWAP: begin
                cfg_err_d   = cfg_wr || cfg_commit;
                pix_ready_s = 1'b0;
                swap_s      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept_s = pix_valid_i && pix_ready_s;

    // Pixel and frame counting.
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        if (accept_s && (pix_cnt_q == LAST_PIX)) begin
            pix_cnt_d    = '0;
            frame_cnt_d  = frame_cnt_q + FCNT_ONE;
            frame_done_d = 1'b1;
        end else if (accept_s) begin
            pix_cnt_d = pix_cnt_q + CNT_ONE;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    matrix_coef_ctrl_coef_bank u_shadow (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (shadow_wr_s),
        .wr_idx_i   (cfg_addr),
        .wr_data_i  (cfg_data),
        .load_en_i  (1'b0),
        .load_data_i(active_bank_s),
        .bank_o     (shadow_bank_s)
    );

    matrix_coef_ctrl_coef_bank u_active (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (1'b0),
        .wr_idx_i   (cfg_addr),
        .wr_data_i  (cfg_data),
        .load_en_i  (swap_s),
        .load_data_i(shadow_bank_s),
        .bank_o     (active_bank_s)
    );

`ifdef COEF_READBACK_EN
    logic [COEF_W-1:0] rdata_q, rdata_d;

    // Readback of the active bank; out-of-range addresses read as zero.
    always_comb begin
        if (cfg_addr <= 4'd8) begin
            rdata_d = active_bank_s[coef_lsb(cfg_addr) +: COEF_W];
        end else begin
            rdata_d = '0;
        end
    end

    // Readback data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata_o = rdata_q;
`else
    assign cfg_rdata_o = '0;
`endif

    assign cfg_ready_o      = (state_q == ST_IDLE);
    assign commit_pending_o = (state_q != ST_IDLE);
    assign pix_ready_o      = pix_ready_s;
    assign mult_valid_o     = accept_s;
    assign coef_o           = active_bank_s;
    assign frame_done_o     = frame_done_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_matrix_coef_ctrl.sv
// Self-checking bench for matrix_coef_ctrl with FRAME_SIZE=16; optional
// readback checks follow COEF_READBACK_EN.
module tb_matrix_coef_ctrl;

    localparam int FS = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_wr, cfg_commit, pix_valid_i;
    logic [3:0]   cfg_addr;
    logic [17:0]  cfg_data;
    logic         cfg_ready_o, cfg_err_o, pix_ready_o, mult_valid_o;
    logic         commit_pending_o, frame_done_o;
    logic [161:0] coef_o;
    logic [15:0]  frame_cnt_o;
    logic [17:0]  cfg_rdata_o;

    matrix_coef_ctrl #(.FRAME_SIZE(FS)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_ready_o(cfg_ready_o),
        .cfg_err_o(cfg_err_o), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .mult_valid_o(mult_valid_o), .coef_o(coef_o),
        .commit_pending_o(commit_pending_o), .frame_done_o(frame_done_o),
        .frame_cnt_o(frame_cnt_o), .cfg_rdata_o(cfg_rdata_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: phase 0 = accepting config, 1 = commit waiting for frame start, 2 = swap cycle.
    int          phase_m, cnt_m, fcnt_m;
    bit          done_m, err_m;
    logic [17:0] shadow_m [9];
    logic [17:0] active_m [9];
    logic [17:0] rdata_m;

    task automatic check(input string nm, input logic [161:0] act, input logic [161:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [161:0] pack_m();
        logic [161:0] p;
        for (int k = 0; k < 9; k++) p[18*(8-k) +: 18] = active_m[k];
        return p;
    endfunction

    function automatic bit pix_ready_m();
        return !(phase_m == 2 || (phase_m == 1 && cnt_m == 0));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            shadow_m[k] = (k == 0 || k == 4 || k == 8) ? 18'd1024 : 18'd0;
            active_m[k] = shadow_m[k];
        end
        phase_m = 0; cnt_m = 0; fcnt_m = 0;
        done_m = 1'b0; err_m = 1'b0; rdata_m = 18'd0;
    endtask

    task automatic model_step();
        bit acc;
        acc = pix_valid_i && pix_ready_m();
`ifdef COEF_READBACK_EN
        rdata_m = (cfg_addr <= 4'd8) ? active_m[cfg_addr] : 18'd0;
`else
        rdata_m = 18'd0;
`endif
        if (phase_m == 0) begin
            err_m = cfg_wr && (cfg_addr > 4'd8);
            if (cfg_wr && cfg_addr <= 4'd8) shadow_m[cfg_addr] = cfg_data;
            if (cfg_commit) phase_m = 1;
        end else if (phase_m == 1) begin
            err_m = cfg_wr || cfg_commit;
            if (cnt_m == 0) phase_m = 2;
        end else begin
            err_m = cfg_wr || cfg_commit;
            for (int k = 0; k < 9; k++) active_m[k] = shadow_m[k];
            phase_m = 0;
        end
        done_m = acc && (cnt_m == FS - 1);
        if (acc) cnt_m = (cnt_m + 1) % FS;
        if (done_m) fcnt_m = (fcnt_m + 1) % 65536;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_step(); else model_reset();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cfg_ready", {161'd0, cfg_ready_o}, {161'd0, phase_m == 0});
            check("commit_pending", {161'd0, commit_pending_o}, {161'd0, phase_m != 0});
            check("pix_ready", {161'd0, pix_ready_o}, {161'd0, pix_ready_m()});
            check("mult_valid", {161'd0, mult_valid_o}, {161'd0, pix_valid_i && pix_ready_m()});
            check("coef", coef_o, pack_m());
            check("frame_done", {161'd0, frame_done_o}, {161'd0, done_m});
            check("frame_cnt", {146'd0, frame_cnt_o}, {146'd0, 16'(fcnt_m)});
            check("cfg_err", {161'd0, cfg_err_o}, {161'd0, err_m});
            check("cfg_rdata", {144'd0, cfg_rdata_o}, {144'd0, rdata_m});
        end
    end

    initial begin
        reset = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0; pix_valid_i = 1'b0;
        cfg_addr = 4'd0; cfg_data = 18'd0;
        model_reset();
        chk_en = 1'b1;
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // 1: reset values
        check("rst_coef0", {144'd0, coef_o[161:144]}, 162'd1024);
        check("rst_coef1", {144'd0, coef_o[143:126]}, 162'd0);
        check("rst_coef4", {144'd0, coef_o[89:72]}, 162'd1024);
        check("rst_coef8", {144'd0, coef_o[17:0]}, 162'd1024);
        check("rst_ready", {161'd0, cfg_ready_o & pix_ready_o}, 162'd1);

        // 2: write -1 to index 1, commit at pix_cnt==0
        cfg_wr = 1'b1; cfg_addr = 4'd1; cfg_data = 18'h3FFFF; cyc();
        cfg_wr = 1'b0; cfg_commit = 1'b1; cyc();
        cfg_commit = 1'b0;
        check("t2_stall1", {161'd0, pix_ready_o}, 162'd0);
        cyc();
        check("t2_stall2", {161'd0, pix_ready_o}, 162'd0);
        check("t2_old_coef1", {144'd0, coef_o[143:126]}, 162'd0);
        cyc();
        check("t2_new_coef1", {144'd0, coef_o[143:126]}, {144'd0, 18'h3FFFF});
        check("t2_ready_back", {161'd0, pix_ready_o}, 162'd1);

        // 3: commit mid-frame at pix_cnt==5 with continuous valid
        pix_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        cfg_commit = 1'b1; cyc();
        cfg_commit = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("t3_frame_done", {161'd0, frame_done_o}, 162'd1);
        check("t3_frame_cnt", {146'd0, frame_cnt_o}, 162'd1);
        check("t3_pending", {161'd0, commit_pending_o}, 162'd1);
        cyc(); cyc();
        check("t3_swapped", {161'd0, commit_pending_o}, 162'd0);
        pix_valid_i = 1'b0;

        // 4: write rejected while pending
        pix_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        pix_valid_i = 1'b0;
        cfg_commit = 1'b1; cyc();
        cfg_commit = 1'b0; cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_data = 18'h00100; cyc();
        cfg_wr = 1'b0;
        check("t4_err_pulse", {161'd0, cfg_err_o}, 162'd1);
        cyc();
        check("t4_err_clear", {161'd0, cfg_err_o}, 162'd0);
        pix_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) cyc();
        check("t4_coef2_kept", {144'd0, coef_o[125:108]}, 162'd0);
        pix_valid_i = 1'b0;

        // 5: bad address, then write+commit in the same cycle
        cfg_wr = 1'b1; cfg_addr = 4'd9; cfg_data = 18'h00005; cyc();
        check("t5_err_addr9", {161'd0, cfg_err_o}, 162'd1);
        cfg_addr = 4'd3; cfg_data = 18'h12345; cfg_commit = 1'b1; cyc();
        cfg_wr = 1'b0; cfg_commit = 1'b0; pix_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        check("t5_coef3", {144'd0, coef_o[107:90]}, {144'd0, 18'h12345});

        // 6: reset while pending at pix_cnt==7
        for (int i = 0; i < 40; i++) begin
            if (cnt_m == 5 && phase_m == 0) break;
            cyc();
        end
        pix_valid_i = 1'b0; cfg_commit = 1'b1; cyc();
        cfg_commit = 1'b0; pix_valid_i = 1'b1; cyc(); cyc();
        pix_valid_i = 1'b0;
        check("t6_pending", {161'd0, commit_pending_o}, 162'd1);
        #2;
        reset = 1'b0; model_reset();
        #1;
        check("t6_rst_pending", {161'd0, commit_pending_o}, 162'd0);
        check("t6_rst_coef3", {144'd0, coef_o[107:90]}, 162'd0);
        check("t6_rst_coef4", {144'd0, coef_o[89:72]}, 162'd1024);
        cyc();
        reset = 1'b1; cfg_addr = 4'd4; cyc();
`ifdef COEF_READBACK_EN
        check("t6_rdata", {144'd0, cfg_rdata_o}, 162'd1024);
        cfg_addr = 4'd10; cyc();
        check("t6_rdata_oob", {144'd0, cfg_rdata_o}, 162'd0);
`else
        check("t6_rdata_tied", {144'd0, cfg_rdata_o}, 162'd0);
`endif
        cyc();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
